control_pipeline: RTL
=====================

// Module: control_pipeline
// PURPOSE
// - Consumer end of the decoder control bundles {tWB, tM, tEX, jump}. Carries them through
//   the ID/EX, EX/MEM and MEM/WB pipeline registers and unpacks them into per-stage strobes.
// - Also tracks destination registers per stage. From these it generates forwarding
//   selects, load-use stalls, branch/jump redirects and bubble/flush insertion.
// - Sits between the control decoder (ID stage) and the datapath pipeline registers.
// PARAMETERS
// - REG_AW  5  register-address width
// PORTS
// clk            in   1       rising-edge clock
// rst_n          in   1       asynchronous active-low reset
// id_wb          in   2       {RegWrite, MemToReg}
// id_m           in   3       {MemWrite, MemRead, Branch}
// id_ex          in   5       {ALUSrc, ALUOp[2:0], RegDst}
// id_jump        in   1       jump decoded in ID
// id_rs          in   REG_AW  rs field of the ID instruction
// id_rt          in   REG_AW  rt field of the ID instruction
// id_rd          in   REG_AW  rd field of the ID instruction
// ex_zero        in   1       ALU zero flag of the EX instruction
// ex_alu_src     out  1       EX-stage ALUSrc
// ex_alu_op      out  3       EX-stage ALUOp
// ex_wreg        out  REG_AW  EX destination: RegDst ? rd : rt
// fwd_a          out  2       ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
// fwd_b          out  2       ALU operand B select; same encoding as fwd_a
// mem_write      out  1       MEM-stage MemWrite
// mem_read       out  1       MEM-stage MemRead
// pc_src         out  1       branch taken: MEM Branch & registered zero
// wb_reg_write   out  1       WB-stage RegWrite
// wb_mem_to_reg  out  1       WB-stage MemToReg
// wb_wreg        out  REG_AW  WB-stage destination register
// pc_write       out  1       0 freezes the PC
// if_id_write    out  1       0 freezes the IF/ID register
// if_id_flush    out  1       1 squashes IF/ID on the next edge
// BEHAVIOUR
// - Reset (rst_n=0, async): all stage registers cleared. All outputs 0, except
//   pc_write = 1 and if_id_write = 1.
// - Latency: an ID bundle appears on ex_* 1 edge later, on mem_*/pc_src 2 edges later,
//   and on wb_* 3 edges later.
// - Load-use: stall = ex_memread & (ex_wreg != 0) & (ex_wreg == id_rs | ex_wreg == id_rt).
//   On stall: pc_write = 0, if_id_write = 0, and a bubble (all-zero bundle) enters ID/EX.
// - Branch: EX/MEM captures Branch and ex_zero; pc_src = mem_branch & mem_zero.
//   When pc_src = 1: if_id_flush = 1, a bubble enters ID/EX and EX/MEM, and the stall is
//   ignored (flush has priority over stall).
// - Jump: id_jump = 1 with no pc_src -> if_id_flush = 1. The ID/EX bundle still loads.
// - Forward A: EX/MEM has priority over MEM/WB.
//   - 10 if mem_regwrite & (mem_wreg != 0) & (mem_wreg == ex_rs).
//   - else 01 if wb_reg_write & (wb_wreg != 0) & (wb_wreg == ex_rs).
//   - else 00. Forward B: identical rule using ex_rt.
// - Register 0 is never a forwarding source or a stall cause.
// - Bubbles clear RegWrite, MemWrite, MemRead and Branch, so no architectural side effect.
// - Unknown bundles are treated as-is. No opcode knowledge lives here.
// - MEM/WB and EX/MEM are never stalled; only ID/EX is bubbled.
// - Reset mid-operation discards all in-flight bundles; no partial writes are issued.
// STRUCTURE
// - Shared package cpu_ctrl_pkg holds:
//   - bit-index localparams for the tWB, tM and tEX fields;
//   - ALUOp codes;
//   - FWD_REG = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
// - One sub-module: hazard_forward_unit, purely combinational, producing stall, fwd_a
//   and fwd_b. Pipeline registers stay in control_pipeline.
// TESTING
// - R-type bundle wb=10, m=000, ex=00101, rd=5, 3 edges:
//   ex_alu_op = 010, ex_wreg = 5, wb_reg_write = 1, wb_wreg = 5.
// - lw rt=2, then add rs=2 the next cycle: 1 cycle of pc_write = 0, if_id_write = 0,
//   bubble in EX. The following cycle fwd_a = 01.
// - add rd=3, then sub rs=3, rt=3 back-to-back: fwd_a = 10, fwd_b = 10.
//   Same pattern with rd=0: both 00.
// - beq with ex_zero = 1: 1 edge later pc_src = 1 and if_id_flush = 1.
//   On the next edge the ex_* and mem_* strobes are all 0.
// - Jump id_jump = 1 -> if_id_flush = 1 that cycle, and pc_write stays 1.
// - Assert rst_n = 0 mid-stream between edges: all outputs 0 immediately, except
//   pc_write = 1 and if_id_write = 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle layout, ALUOp codes and forwarding selects for the
// decoder / control-pipeline pair.
package cpu_ctrl_pkg;

    // Bundle field widths
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 5;

    // tWB bit indices: {RegWrite, MemToReg}
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // tM bit indices: {MemWrite, MemRead, Branch}
    localparam int M_MEM_WRITE = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_BRANCH    = 0;

    // tEX bit indices: {ALUSrc, ALUOp[2:0], RegDst}
    localparam int EX_ALU_SRC   = 4;
    localparam int EX_ALU_OP_HI = 3;
    localparam int EX_ALU_OP_LO = 1;
    localparam int EX_REG_DST   = 0;

    // ALUOp codes as produced by the decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Control bundle as it travels down the pipe
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_bundle_t;

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational hazard detection: load-use stall request and ALU operand
// forwarding selects. Register 0 never counts as a producer.
import cpu_ctrl_pkg::*;

module hazard_forward_unit #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_wreg,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // Load in EX whose result is needed by the instruction in ID
    always_comb begin
        stall = ex_mem_read && (ex_wreg != '0) &&
                ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    end

    // Operand selects; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        mem_fwd_ok = mem_reg_write && (mem_wreg != '0);
        wb_fwd_ok  = wb_reg_write  && (wb_wreg  != '0);

        fwd_a = FWD_REG;
        if (mem_fwd_ok && (mem_wreg == ex_rs))     fwd_a = FWD_MEM;
        else if (wb_fwd_ok && (wb_wreg == ex_rs))  fwd_a = FWD_WB;

        fwd_b = FWD_REG;
        if (mem_fwd_ok && (mem_wreg == ex_rt))     fwd_b = FWD_MEM;
        else if (wb_fwd_ok && (wb_wreg == ex_rt))  fwd_b = FWD_WB;
    end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoder control bundles through ID/EX, EX/MEM and MEM/WB, unpacks
// per-stage strobes, and inserts stalls, bubbles and flushes.
import cpu_ctrl_pkg::*;

module control_pipeline #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        id_wb,
    input  logic [2:0]        id_m,
    input  logic [4:0]        id_ex,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              ex_alu_src,
    output logic [2:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_write,
    output logic              mem_read,
    output logic              pc_src,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_wreg,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush
);

    // ID/EX
    ctrl_bundle_t      idex_ctrl_d, idex_ctrl_q;
    logic [REG_AW-1:0] idex_rs_d, idex_rs_q;
    logic [REG_AW-1:0] idex_rt_d, idex_rt_q;
    logic [REG_AW-1:0] idex_rd_d, idex_rd_q;
    // EX/MEM
    logic [WB_W-1:0]   exmem_wb_d, exmem_wb_q;
    logic [M_W-1:0]    exmem_m_d, exmem_m_q;
    logic [REG_AW-1:0] exmem_wreg_d, exmem_wreg_q;
    logic              exmem_zero_d, exmem_zero_q;
    // MEM/WB
    logic [WB_W-1:0]   memwb_wb_d, memwb_wb_q;
    logic [REG_AW-1:0] memwb_wreg_d, memwb_wreg_q;

    ctrl_bundle_t id_ctrl;
    logic         stall;
    logic         stall_eff;

    assign id_ctrl = '{wb: id_wb, m: id_m, ex: id_ex};

    // Per-stage strobes unpacked from the pipeline registers
    always_comb begin
        ex_alu_src    = idex_ctrl_q.ex[EX_ALU_SRC];
        ex_alu_op     = idex_ctrl_q.ex[EX_ALU_OP_HI:EX_ALU_OP_LO];
        ex_wreg       = idex_ctrl_q.ex[EX_REG_DST] ? idex_rd_q : idex_rt_q;
        mem_write     = exmem_m_q[M_MEM_WRITE];
        mem_read      = exmem_m_q[M_MEM_READ];
        pc_src        = exmem_m_q[M_BRANCH] & exmem_zero_q;
        wb_reg_write  = memwb_wb_q[WB_REG_WRITE];
        wb_mem_to_reg = memwb_wb_q[WB_MEM_TO_REG];
        wb_wreg       = memwb_wreg_q;
    end

    hazard_forward_unit #(.REG_AW(REG_AW)) u_hazard (
        .ex_mem_read   (idex_ctrl_q.m[M_MEM_READ]),
        .ex_wreg       (ex_wreg),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_rs         (idex_rs_q),
        .ex_rt         (idex_rt_q),
        .mem_reg_write (exmem_wb_q[WB_REG_WRITE]),
        .mem_wreg      (exmem_wreg_q),
        .wb_reg_write  (memwb_wb_q[WB_REG_WRITE]),
        .wb_wreg       (memwb_wreg_q),
        .stall         (stall),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Front-end control; a taken branch overrides any load-use stall
    always_comb begin
        stall_eff   = stall & ~pc_src;
        pc_write    = ~stall_eff;
        if_id_write = ~stall_eff;
        if_id_flush = pc_src | id_jump;
    end

    // Next-state: bubble ID/EX on stall or redirect, bubble EX/MEM on redirect
    always_comb begin
        idex_ctrl_d = id_ctrl;
        idex_rs_d   = id_rs;
        idex_rt_d   = id_rt;
        idex_rd_d   = id_rd;
        if (stall_eff || pc_src) begin
            idex_ctrl_d = '0;
            idex_rs_d   = '0;
            idex_rt_d   = '0;
            idex_rd_d   = '0;
        end

        exmem_wb_d   = idex_ctrl_q.wb;
        exmem_m_d    = idex_ctrl_q.m;
        exmem_wreg_d = ex_wreg;
        exmem_zero_d = ex_zero;
        if (pc_src) begin
            exmem_wb_d   = '0;
            exmem_m_d    = '0;
            exmem_wreg_d = '0;
            exmem_zero_d = 1'b0;
        end

        memwb_wb_d   = exmem_wb_q;
        memwb_wreg_d = exmem_wreg_q;
    end

    // Pipeline registers; reset drops every in-flight bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl_q  <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            exmem_wb_q   <= '0;
            exmem_m_q    <= '0;
            exmem_wreg_q <= '0;
            exmem_zero_q <= 1'b0;
            memwb_wb_q   <= '0;
            memwb_wreg_q <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
            exmem_wb_q   <= exmem_wb_d;
            exmem_m_q    <= exmem_m_d;
            exmem_wreg_q <= exmem_wreg_d;
            exmem_zero_q <= exmem_zero_d;
            memwb_wb_q   <= memwb_wb_d;
            memwb_wreg_q <= memwb_wreg_d;
        end
    end

endmodule
